// File: rtl/hazard_pkg.sv
// Shared types and forwarding-select encodings for the hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_BUSY,
      MD_DONE
   } md_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_md_seq.sv
// Multi-cycle execute sequencer: holds E for MD_LATENCY cycles, then pulses mdDone.
//  state   | meaning
//  MD_IDLE | no multi-cycle op in E; a start stalls immediately and loads the timer
//  MD_BUSY | op in progress; stall until the down-counter reaches zero
//  MD_DONE | result valid for one cycle; op leaves E next cycle
module hazard_md_seq
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic mdStart,
   output logic mdStall,
   output logic mdDone
);

   localparam int CW = ($clog2(MD_LATENCY) < 1) ? 1 : $clog2(MD_LATENCY);
   // The IDLE start cycle is the first stall cycle, so the timer covers the rest.
   localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY - 2);

   md_state_t state, stateNext;
   logic [CW-1:0] cnt, cntNext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      mdStall   = 1'b0;
      mdDone    = 1'b0;
      case (state)
         MD_IDLE: begin
            if (mdStart) begin
               mdStall   = 1'b1;
               cntNext   = LOAD_VAL;
               stateNext = MD_BUSY;
            end
         end
         MD_BUSY: begin
            mdStall = 1'b1;
            if (cnt == '0) begin
               stateNext = MD_DONE;
            end else begin
               cntNext = cnt - CW'(1);
            end
         end
         MD_DONE: begin
            mdDone    = 1'b1;
            stateNext = MD_IDLE;
         end
         default: begin
            stateNext = MD_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/hazard_control_mc.sv
// Pipeline hazard/forwarding controller with multi-cycle execute support.
// HAZARD_PERF_CNT_EN enables saturating stall/flush performance counters.
module hazard_control_mc
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*REG_AW-1:0] RsD,
   input  logic [NUM_SRC*REG_AW-1:0] RsE,
   input  logic [REG_AW-1:0]         RdE,
   input  logic                      ResultSrcE0,
   input  logic                      MdStartE,
   input  logic                      PCSrcE,
   input  logic [REG_AW-1:0]         RdM,
   input  logic                      RegWriteM,
   input  logic [REG_AW-1:0]         RdW,
   input  logic                      RegWriteW,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      StallE,
   output logic                      FlushD,
   output logic                      FlushE,
   output logic                      FlushM,
   output logic [2*NUM_SRC-1:0]      ForwardE,
   output logic                      MdBusy,
   output logic                      MdDone,
   output logic [CNT_W-1:0]          StallCnt,
   output logic [CNT_W-1:0]          FlushCnt
);

   logic mdStall;
   logic lwStall;
   logic brFlush;
   logic [NUM_SRC-1:0] lwHit;

   hazard_md_seq #(
      .MD_LATENCY(MD_LATENCY)
   ) uMdSeq (
      .clk     (clk),
      .reset   (reset),
      .mdStart (MdStartE),
      .mdStall (mdStall),
      .mdDone  (MdDone)
   );

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gSrc
      logic [REG_AW-1:0] rsD;
      logic [REG_AW-1:0] rsE;
      logic [1:0]        fwdSel;

      assign rsD = RsD[gi*REG_AW +: REG_AW];
      assign rsE = RsE[gi*REG_AW +: REG_AW];
      assign lwHit[gi] = (rsD == RdE) && (rsD != '0);

      // M is the younger producer, so it wins over W.
      always_comb begin
         fwdSel = FWD_RF;
         if ((rsE == RdM) && RegWriteM && (rsE != '0)) begin
            fwdSel = FWD_MEM;
         end else if ((rsE == RdW) && RegWriteW && (rsE != '0)) begin
            fwdSel = FWD_WB;
         end
      end

      assign ForwardE[2*gi +: 2] = fwdSel;
   end

   assign lwStall = ResultSrcE0 && (|lwHit);
   assign brFlush = PCSrcE && !mdStall;

   assign StallF = lwStall || mdStall;
   assign StallD = StallF;
   assign StallE = mdStall;
   assign FlushD = brFlush;
   assign FlushE = (lwStall && !mdStall) || brFlush;
   assign FlushM = mdStall;
   assign MdBusy = mdStall;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stallCntQ;
   logic [CNT_W-1:0] flushCntQ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCntQ <= '0;
         flushCntQ <= '0;
      end else begin
         if (StallF && (stallCntQ != '1)) stallCntQ <= stallCntQ + CNT_W'(1);
         if (brFlush && (flushCntQ != '1)) flushCntQ <= flushCntQ + CNT_W'(1);
      end
   end

   assign StallCnt = stallCntQ;
   assign FlushCnt = flushCntQ;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_control_mc.sv
// Scoreboard bench for hazard_control_mc: directed cases then random traffic vs. a reference model.
module tb_hazard_control_mc;

   localparam int REG_AW     = 5;
   localparam int NUM_SRC    = 2;
   localparam int MD_LATENCY = 4;
   localparam int CNT_W      = 3;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic [NUM_SRC*REG_AW-1:0] RsD = '0, RsE = '0;
   logic [REG_AW-1:0]         RdE = '0, RdM = '0, RdW = '0;
   logic                      ResultSrcE0 = 1'b0, MdStartE = 1'b0, PCSrcE = 1'b0;
   logic                      RegWriteM = 1'b0, RegWriteW = 1'b0;
   logic                      StallF, StallD, StallE, FlushD, FlushE, FlushM;
   logic [2*NUM_SRC-1:0]      ForwardE;
   logic                      MdBusy, MdDone;
   logic [CNT_W-1:0]          StallCnt, FlushCnt;

   hazard_control_mc #(
      .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .RsD(RsD), .RsE(RsE), .RdE(RdE),
      .ResultSrcE0(ResultSrcE0), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
      .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .ForwardE(ForwardE), .MdBusy(MdBusy), .MdDone(MdDone),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]           stall;   // F, D, E
      logic [2:0]           flush;   // D, E, M
      logic [2*NUM_SRC-1:0] fwd;
      logic [1:0]           md;      // busy, done
      logic [CNT_W-1:0]     sCnt;
      logic [CNT_W-1:0]     fCnt;
   } exp_t;

   exp_t expQ[$];
   exp_t cur;
   int   nCmp = 0;
   int   nBad = 0;

   // Reference model: age of the multi-cycle op in E (-1 = none), plus event counts.
   int mdAge = -1;
   int sCntM = 0;
   int fCntM = 0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
      nCmp++;
      if (act !== req) begin
         nBad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         cur = expQ.pop_front();
         check("stall", 32'({StallF, StallD, StallE}), 32'(cur.stall));
         check("flush", 32'({FlushD, FlushE, FlushM}), 32'(cur.flush));
         check("fwd",   32'(ForwardE), 32'(cur.fwd));
         check("md",    32'({MdBusy, MdDone}), 32'(cur.md));
         check("stallCnt", 32'(StallCnt), 32'(cur.sCnt));
         check("flushCnt", 32'(FlushCnt), 32'(cur.fCnt));
      end
   end

   // Drive one cycle of inputs, predict the outputs, then move to the next cycle.
   task automatic issue(input logic rst, input logic [NUM_SRC*REG_AW-1:0] rsd,
                        input logic [NUM_SRC*REG_AW-1:0] rse, input logic [REG_AW-1:0] rde,
                        input logic ld, input logic md, input logic pc,
                        input logic [REG_AW-1:0] rdm, input logic wm,
                        input logic [REG_AW-1:0] rdw, input logic ww);
      exp_t e;
      int   effAge;
      bit   mdS, done, lw;
      logic [REG_AW-1:0] s;
      reset = rst; RsD = rsd; RsE = rse; RdE = rde; ResultSrcE0 = ld;
      MdStartE = md; PCSrcE = pc; RdM = rdm; RegWriteM = wm; RdW = rdw; RegWriteW = ww;
      if (rst) begin
         mdAge = -1; sCntM = 0; fCntM = 0;
      end
      effAge = (mdAge < 0 && md) ? 0 : mdAge;
      mdS  = (effAge >= 0) && (effAge < MD_LATENCY);
      done = (effAge == MD_LATENCY);
      lw = 1'b0;
      e.fwd = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         s = rsd[i*REG_AW +: REG_AW];
         if (ld && s == rde && s != 0) lw = 1'b1;
         s = rse[i*REG_AW +: REG_AW];
         if (s != 0 && wm && s == rdm)      e.fwd[2*i +: 2] = 2'b10;
         else if (s != 0 && ww && s == rdw) e.fwd[2*i +: 2] = 2'b01;
      end
      e.stall = {lw | mdS, lw | mdS, mdS};
      e.flush = {pc & !mdS, (lw | pc) & !mdS, mdS};
      e.md    = {mdS, done};
`ifdef HAZARD_PERF_CNT_EN
      e.sCnt = CNT_W'(sCntM);
      e.fCnt = CNT_W'(fCntM);
`else
      e.sCnt = '0;
      e.fCnt = '0;
`endif
      expQ.push_back(e);
      if (!rst) begin
         mdAge = (effAge < 0 || effAge == MD_LATENCY) ? -1 : effAge + 1;
         if ((lw | mdS) && sCntM < CNT_MAX) sCntM++;
         if ((pc & !mdS) && fCntM < CNT_MAX) fCntM++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mdCycle(input logic md, input logic pc);
      issue(1'b0, '0, '0, '0, 1'b0, md, pc, '0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      logic [NUM_SRC*REG_AW-1:0] rsd, rse;
      @(posedge clk);
      #1;
      issue(1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      // Load-use hazard on source 1, then the x0 case.
      issue(1'b0, {5'd5, 5'd0}, '0, 5'd5, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      issue(1'b0, '0, '0, 5'd0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      // Forwarding priority and x0.
      issue(1'b0, '0, {5'd0, 5'd7}, '0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1);
      issue(1'b0, '0, {5'd0, 5'd7}, '0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1);
      issue(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
      // Single multi-cycle op held 5 cycles.
      for (int i = 0; i < 5; i++) mdCycle(1'b1, 1'b0);
      mdCycle(1'b0, 1'b0);
      // Back-to-back ops with a branch resolving during BUSY.
      for (int i = 0; i < 10; i++) mdCycle(1'b1, (i == 1 || i == 2));
      mdCycle(1'b0, 1'b1);
      // Reset in the middle of BUSY.
      mdCycle(1'b1, 1'b0);
      mdCycle(1'b1, 1'b0);
      issue(1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      mdCycle(1'b0, 1'b0);
      mdCycle(1'b0, 1'b0);
      // Long stall run to exercise counter saturation.
      for (int i = 0; i < 10; i++)
         issue(1'b0, {5'd3, 5'd3}, '0, 5'd3, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      mdCycle(1'b0, 1'b1);
      // Random traffic on a small register range to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            rsd[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            rse[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
         end
         issue(($urandom_range(0, 59) == 0), rsd, rse,
               REG_AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
               REG_AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               REG_AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      mdCycle(1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("queueDrained", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/hazard_control_mc.md
# hazard_control_mc

Hazard and forwarding controller for the 5-stage RISC-V pipeline, parametrised in register-index width and source-operand count. It adds support for a multi-cycle execute unit (mul/div) that holds the Execute stage for a fixed number of cycles. It sits beside the datapath and drives stage stall/flush enables and the Execute-stage forwarding mux selects. Load-use stalls, branch flushes and M/W forwarding keep the established pipeline semantics.

## Interface
- REG_AW, 5, register index width
- NUM_SRC, 2, source operands per instruction (1..3)
- MD_LATENCY, 4, multi-cycle unit stall cycles (≥2)
- CNT_W, 32, performance counter width
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- RsD  in  NUM_SRC*REG_AW  Decode source indices, source i at [i*REG_AW +: REG_AW]
- RsE  in  NUM_SRC*REG_AW  Execute source indices, same packing
- RdE  in  REG_AW  Execute destination
- ResultSrcE0  in  1  Execute instruction is a load
- MdStartE  in  1  Execute instruction is a multi-cycle op; held while it occupies E
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM, RegWriteM  in  REG_AW, 1  Memory-stage destination/write enable
- RdW, RegWriteW  in  REG_AW, 1  Writeback-stage destination/write enable
- StallF, StallD, StallE  out  1  hold IF, IF/ID, ID/EX registers
- FlushD, FlushE, FlushM  out  1  clear IF/ID, ID/EX, EX/MEM registers
- ForwardE  out  2*NUM_SRC  per-source select at [2i +: 2]: 00 regfile, 01 W, 10 M
- MdBusy  out  1  multi-cycle unit occupying E
- MdDone  out  1  multi-cycle result valid this cycle
- StallCnt, FlushCnt  out  CNT_W  performance counters

## Operation
- Multi-cycle FSM (md_state_t): IDLE, BUSY, DONE.
  - IDLE and MdStartE: assert md stall, load counter with MD_LATENCY-2, go to BUSY.
  - BUSY: assert md stall; at counter 0 go to DONE, otherwise decrement.
  - DONE: no md stall, MdDone=1, go to IDLE unconditionally. MdStartE still high in DONE never restarts the FSM.
- mdStall = (IDLE & MdStartE) | BUSY. MdBusy = mdStall.
- lwStall = ResultSrcE0 & (any i: RsD[i]==RdE & RsD[i]!=0).
- StallF = StallD = lwStall | mdStall. StallE = mdStall.
- FlushD = PCSrcE & ~mdStall.
- FlushE = (lwStall & ~mdStall) | (PCSrcE & ~mdStall).
- FlushM = mdStall (bubble into M while E is held).
- Forwarding per source i, with M taking priority over W:
  - 10 if RsE[i]==RdM & RegWriteM & RsE[i]!=0;
  - else 01 if RsE[i]==RdW & RegWriteW & RsE[i]!=0;
  - else 00.
- Counter width is ceil(log2(MD_LATENCY)), minimum 1.

## Timing
- All stall/flush/forward outputs are combinational from inputs and FSM state, valid in the same cycle.
- A multi-cycle op in E is stalled for exactly MD_LATENCY cycles and leaves E on the cycle after DONE. Total residency in E is MD_LATENCY+1 cycles.
- Reset (asynchronous, any state including mid-BUSY): FSM goes to IDLE, counter 0, StallCnt/FlushCnt 0. All outputs then follow the combinational rules, so they are 0 with idle inputs and MdDone=0.
- Back-to-back multi-cycle ops: the second op reaches E in the cycle after DONE, sees IDLE, and restarts. There is no gap cycle.
- lwStall and PCSrcE while mdStall: both are ignored for flushing; mdStall has priority.
- PCSrcE together with lwStall: FlushE=1, FlushD=1, StallF=StallD=1. The redirect is taken by the PC mux.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments each cycle StallF=1.
  - FlushCnt increments each cycle PCSrcE causes FlushE.
  - Both saturate at all-ones and clear on reset.
- Undefined: no counter flops; StallCnt and FlushCnt are driven constant 0. The ports remain.

## Structure
- hazard_pkg holds:
  - md_state_t enum {MD_IDLE, MD_BUSY, MD_DONE};
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, hazard_md_seq: the FSM plus down-counter, parametrised by MD_LATENCY, outputting mdStall and MdDone.
- Forwarding and load-use logic use a generate loop over NUM_SRC in the top module.

## Test plan
- Load x5 in E (ResultSrcE0=1, RdE=5), RsD source1=5 -> StallF=StallD=FlushE=1, StallE=0. With RsD=0 and RdE=0 -> no stall.
- RsE source0=7, RdM=7/RegWriteM=1 and RdW=7/RegWriteW=1 -> ForwardE[1:0]=10. With RegWriteM=0 -> 01. With RsE=0 -> 00.
- MD_LATENCY=4, MdStartE high 5 cycles -> StallF/D/E and FlushM high cycles 0–3, MdDone=1 in cycle 4 only, then the FSM is IDLE.
- Back-to-back multi-cycle ops (MdStartE high 10 cycles) -> two stall windows of 4, one DONE cycle between them. PCSrcE=1 during BUSY -> FlushD=FlushE=0.
- reset pulsed in BUSY cycle 2 -> MdBusy=0 immediately; with MdStartE low after reset, no stall.
- HAZARD_PERF_CNT_EN defined, CNT_W=3, 10 stall cycles -> StallCnt holds at 7. Undefined -> StallCnt=0 throughout.
